// File: rtl/aud_pcm_refill_sched.sv
// PCM ring refill scheduler: copies source words into the device sample ring as play space frees up.
// Build option AUD_PCM_REFILL_IRQ_EN adds the irqLow near-underrun / fault level.
//
// state  | meaning
// IDLE   | stopped; waits for enable with a non-empty source and no fault
// CHECK  | waits until at least CHUNK ring words have been consumed
// RD     | memory read request held until OK or FAULT
// RDREL  | read request dropped, waits for memory READY
// WR     | device write request held until OK or FAULT
// WRREL  | write request dropped, waits for device READY, then advances pointers
module aud_pcm_refill_sched #(
    parameter int unsigned CHUNK    = 16,
    parameter logic [31:0] DEV_BASE = 32'h0009_0000,
    parameter logic [4:0]  OPM_RD   = 5'h0A,
    parameter logic [4:0]  OPM_WR   = 5'h12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cfgEnable,
    input  logic        cfgLoop,
    input  logic [31:0] cfgSrcBase,
    input  logic [15:0] cfgSrcLen,
    input  logic [10:0] playPos,
    output logic [31:0] memAddr,
    output logic [4:0]  memOpm,
    input  logic [31:0] memInData,
    input  logic [1:0]  memOK,
    output logic [31:0] devAddr,
    output logic [31:0] devOutData,
    output logic [4:0]  devOpm,
    input  logic [1:0]  devOK,
    output logic        busy,
    output logic        done,
    output logic        fault
`ifdef AUD_PCM_REFILL_IRQ_EN
    ,
    output logic        irqLow
`endif
);

    localparam logic [1:0] RSP_READY = 2'd0;
    localparam logic [1:0] RSP_OK    = 2'd1;
    localparam logic [1:0] RSP_FAULT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_RD, S_RDREL, S_WR, S_WRREL
    } state_t;

    state_t      state;
    logic [10:0] wrPtr;
    logic [15:0] srcIdx;
    logic [8:0]  chunkCnt;
    logic [31:0] data_q;

    // One ring word is always left empty, so wrPtr == playPos reads as empty.
    logic [10:0] free;
    logic        room;
    logic [15:0] src_inc;
    logic        src_end;
    logic [15:0] src_next;
    logic [8:0]  chunk_dec;

    assign free      = playPos - wrPtr - 11'd1;
    assign room      = {1'b0, free} >= 12'(CHUNK);
    assign src_inc   = srcIdx + 16'd1;
    assign src_end   = (src_inc == cfgSrcLen);
    assign src_next  = (src_end && cfgLoop) ? 16'd0 : src_inc;
    assign chunk_dec = chunkCnt - 9'd1;

`ifdef AUD_PCM_REFILL_IRQ_EN
    logic [10:0] fill;
    assign fill = 11'd2047 - free;
`endif

    function automatic logic [31:0] src_addr(input logic [15:0] idx);
        return cfgSrcBase + {14'd0, idx, 2'b00};
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            wrPtr      <= '0;
            srcIdx     <= '0;
            chunkCnt   <= '0;
            data_q     <= '0;
            memAddr    <= '0;
            memOpm     <= '0;
            devAddr    <= '0;
            devOutData <= '0;
            devOpm     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
`ifdef AUD_PCM_REFILL_IRQ_EN
            irqLow     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef AUD_PCM_REFILL_IRQ_EN
            irqLow <= fault | (cfgEnable & (fill < 11'd256));
`endif
            case (state)
                S_IDLE: begin
                    if (cfgEnable && (cfgSrcLen != 16'd0) && !fault) begin
                        srcIdx <= '0;
                        busy   <= 1'b1;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!cfgEnable) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (room) begin
                        chunkCnt <= 9'(CHUNK);
                        memAddr  <= src_addr(srcIdx);
                        memOpm   <= OPM_RD;
                        state    <= S_RD;
                    end
                end
                S_RD: begin
                    if (memOK == RSP_OK) begin
                        data_q <= memInData;
                        memOpm <= '0;
                        state  <= S_RDREL;
                    end else if (memOK == RSP_FAULT) begin
                        fault  <= 1'b1;
                        memOpm <= '0;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_RDREL: begin
                    if (memOK == RSP_READY) begin
                        devAddr    <= DEV_BASE + {19'd0, wrPtr, 2'b00};
                        devOutData <= data_q;
                        devOpm     <= OPM_WR;
                        state      <= S_WR;
                    end
                end
                S_WR: begin
                    if (devOK == RSP_OK) begin
                        devOpm <= '0;
                        state  <= S_WRREL;
                    end else if (devOK == RSP_FAULT) begin
                        fault  <= 1'b1;
                        devOpm <= '0;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_WRREL: begin
                    if (devOK == RSP_READY) begin
                        wrPtr    <= wrPtr + 11'd1;
                        chunkCnt <= chunk_dec;
                        srcIdx   <= src_next;
                        // A dropped enable is honoured only here, once the word is fully written.
                        if (src_end && !cfgLoop) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else if (!cfgEnable) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else if (chunk_dec == 9'd0) begin
                            state <= S_CHECK;
                        end else begin
                            memAddr <= src_addr(src_next);
                            memOpm  <= OPM_RD;
                            state   <= S_RD;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aud_pcm_refill_sched.sv
// Directed bench for aud_pcm_refill_sched: bus responders with scripted HOLD/FAULT,
// write/read logs, and hand-computed expected addresses and data.
module tb_aud_pcm_refill_sched;

    localparam logic [4:0] OPM_RD = 5'h0A;
    localparam logic [4:0] OPM_WR = 5'h12;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfgEnable;
    logic        cfgLoop;
    logic [31:0] cfgSrcBase;
    logic [15:0] cfgSrcLen;
    logic [10:0] playPos;
    logic [31:0] memAddr;
    logic [4:0]  memOpm;
    logic [31:0] memInData;
    logic [1:0]  memOK;
    logic [31:0] devAddr;
    logic [31:0] devOutData;
    logic [4:0]  devOpm;
    logic [1:0]  devOK;
    logic        busy;
    logic        done;
    logic        fault;
`ifdef AUD_PCM_REFILL_IRQ_EN
    logic        irqLow;
`endif

    aud_pcm_refill_sched dut (
        .clock(clock), .reset(reset),
        .cfgEnable(cfgEnable), .cfgLoop(cfgLoop),
        .cfgSrcBase(cfgSrcBase), .cfgSrcLen(cfgSrcLen), .playPos(playPos),
        .memAddr(memAddr), .memOpm(memOpm), .memInData(memInData), .memOK(memOK),
        .devAddr(devAddr), .devOutData(devOutData), .devOpm(devOpm), .devOK(devOK),
        .busy(busy), .done(done), .fault(fault)
`ifdef AUD_PCM_REFILL_IRQ_EN
        , .irqLow(irqLow)
`endif
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          hold_left = 0;
    int          dev_fault_on = 0;
    int          dev_attempt = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    logic [31:0] rd_addr [0:63];

    // Memory answers every read in one cycle (after optional HOLDs) with ~address as data;
    // device answers every write in one cycle, faulting the scripted attempt.
    initial begin
        memOK = 2'd0; memInData = '0; devOK = 2'd0;
        forever begin
            @(negedge clock);
            if (memOpm == OPM_RD) begin
                if (hold_left > 0) begin
                    memOK = 2'd2; memInData = 32'hDEAD_BEEF; hold_left--;
                end else begin
                    memOK = 2'd1; memInData = ~memAddr;
                    if (rd_cnt < 64) rd_addr[rd_cnt] = memAddr;
                    rd_cnt++;
                end
            end else begin
                memOK = 2'd0; memInData = '0;
            end
            if (devOpm == OPM_WR) begin
                dev_attempt++;
                if (dev_attempt == dev_fault_on) devOK = 2'd3;
                else begin
                    devOK = 2'd1;
                    if (wr_cnt < 64) begin
                        wr_addr[wr_cnt] = devAddr; wr_data[wr_cnt] = devOutData;
                    end
                    wr_cnt++;
                end
            end else begin
                devOK = 2'd0;
            end
        end
    end

    task automatic clear_logs();
        wr_cnt = 0; rd_cnt = 0; dev_attempt = 0; hold_left = 0; dev_fault_on = 0;
    endtask

    task automatic do_reset();
        cfgEnable = 1'b0; cfgLoop = 1'b0; cfgSrcBase = '0; cfgSrcLen = '0; playPos = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock); #1;
        clear_logs();
    endtask

    task automatic wait_writes(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock); #1;
            if (wr_cnt >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock); #1;
            if (done) begin ok = 1'b1; cfgEnable = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        bit ok;
        do_reset();
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else n_pass++;
        n_checks++; if (memOpm !== 5'd0) $display("FAIL rst_memOpm got %h want 00", memOpm); else n_pass++;
        cfgSrcBase = 32'h0002_0000; cfgSrcLen = 16'd40; playPos = 11'd0; cfgEnable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock); #1;
            if (devOpm == OPM_WR && wr_cnt >= 3) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) $display("FAIL rst_reach_wr timeout got 0 want 1"); else n_pass++;
        reset = 1'b1; cfgEnable = 1'b0;
        #1;
        n_checks++; if (devOpm !== 5'd0) $display("FAIL rst_devOpm got %h want 00", devOpm); else n_pass++;
        n_checks++; if (devAddr !== 32'd0) $display("FAIL rst_devAddr got %h want 0", devAddr); else n_pass++;
        n_checks++; if (devOutData !== 32'd0) $display("FAIL rst_devOutData got %h want 0", devOutData); else n_pass++;
        n_checks++; if (memAddr !== 32'd0) $display("FAIL rst_memAddr got %h want 0", memAddr); else n_pass++;
        n_checks++; if ({busy, done, fault} !== 3'b000) $display("FAIL rst_flags got %b want 000", {busy, done, fault}); else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock); #1;
        clear_logs();
    endtask

    // Runs straight after test_reset without another reset, so the first address also proves wrPtr cleared.
    task automatic test_basic();
        int dones = 0;
        cfgSrcBase = 32'h0002_0000; cfgSrcLen = 16'd40; cfgLoop = 1'b0; playPos = 11'd0;
        cfgEnable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock); #1;
            if (done) begin dones++; cfgEnable = 1'b0; end
        end
        n_checks++; if (wr_cnt !== 40) $display("FAIL basic_count got %0d want 40", wr_cnt); else n_pass++;
        n_checks++; if (dones !== 1) $display("FAIL basic_done got %0d want 1", dones); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy got %0b want 0", busy); else n_pass++;
        n_checks++; if (wr_addr[0] !== 32'h0009_0000) $display("FAIL basic_first_addr got %h want 00090000", wr_addr[0]); else n_pass++;
        n_checks++; if (wr_addr[16] !== 32'h0009_0040) $display("FAIL basic_addr16 got %h want 00090040", wr_addr[16]); else n_pass++;
        n_checks++; if (wr_addr[39] !== 32'h0009_009C) $display("FAIL basic_last_addr got %h want 0009009c", wr_addr[39]); else n_pass++;
        n_checks++; if (wr_data[39] !== ~32'h0002_009C) $display("FAIL basic_last_data got %h want %h", wr_data[39], ~32'h0002_009C); else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        cfgSrcBase = 32'h0005_0000; cfgSrcLen = 16'd100; playPos = 11'd10; cfgEnable = 1'b1;
        repeat (30) @(negedge clock);
        #1;
        n_checks++; if (rd_cnt !== 0 || wr_cnt !== 0) $display("FAIL stall_no_bus got rd=%0d wr=%0d want 0/0", rd_cnt, wr_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL stall_busy got %0b want 1", busy); else n_pass++;
        playPos = 11'd17;
        repeat (150) @(negedge clock);
        #1;
        n_checks++; if (wr_cnt !== 16) $display("FAIL stall_burst got %0d want 16", wr_cnt); else n_pass++;
        n_checks++; if (wr_addr[15] !== 32'h0009_003C) $display("FAIL stall_addr15 got %h want 0009003c", wr_addr[15]); else n_pass++;
        cfgEnable = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL stall_exit got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_hold();
        bit ok;
        int bad = 0;
        do_reset();
        hold_left = 5;
        cfgSrcBase = 32'h0003_0000; cfgSrcLen = 16'd2; cfgEnable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock); #1;
            if (memOpm == OPM_RD) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) $display("FAIL hold_start timeout got 0 want 1"); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); #1;
            if (memOpm !== OPM_RD) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL hold_req_dropped got %0d want 0", bad); else n_pass++;
        wait_done(50, ok);
        n_checks++; if (!ok) $display("FAIL hold_done timeout got 0 want 1"); else n_pass++;
        n_checks++; if (wr_cnt !== 2) $display("FAIL hold_writes got %0d want 2", wr_cnt); else n_pass++;
        n_checks++; if (wr_data[0] !== ~32'h0003_0000) $display("FAIL hold_data got %h want %h", wr_data[0], ~32'h0003_0000); else n_pass++;
        n_checks++; if (wr_data[1] !== ~32'h0003_0004) $display("FAIL hold_data1 got %h want %h", wr_data[1], ~32'h0003_0004); else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        cfgSrcBase = 32'h0000_0000; cfgSrcLen = 16'd2040; playPos = 11'd0; cfgEnable = 1'b1;
        wait_writes(2032, 9000, ok);
        n_checks++; if (!ok) $display("FAIL wrap_pre_fill timeout got %0d want 2032", wr_cnt); else n_pass++;
        playPos = 11'd1000;
        wait_done(300, ok);
        n_checks++; if (!ok || wr_cnt !== 2040) $display("FAIL wrap_pre_done got %0d want 2040", wr_cnt); else n_pass++;
        @(negedge clock); #1;
        clear_logs();
        cfgSrcBase = 32'h0010_0000; cfgSrcLen = 16'd20; cfgLoop = 1'b1; cfgEnable = 1'b1;
        wait_writes(24, 300, ok);
        cfgEnable = 1'b0;
        repeat (10) @(negedge clock);
        #1;
        n_checks++; if (!ok || wr_cnt !== 24) $display("FAIL wrap_count got %0d want 24", wr_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL wrap_stop got %0b want 0", busy); else n_pass++;
        n_checks++; if (wr_addr[0] !== 32'h0009_1FE0) $display("FAIL wrap_addr0 got %h want 00091fe0", wr_addr[0]); else n_pass++;
        n_checks++; if (wr_addr[7] !== 32'h0009_1FFC) $display("FAIL wrap_addr7 got %h want 00091ffc", wr_addr[7]); else n_pass++;
        n_checks++; if (wr_addr[8] !== 32'h0009_0000) $display("FAIL wrap_addr8 got %h want 00090000", wr_addr[8]); else n_pass++;
        n_checks++; if (rd_addr[19] !== 32'h0010_004C) $display("FAIL wrap_src19 got %h want 0010004c", rd_addr[19]); else n_pass++;
        n_checks++; if (rd_addr[20] !== 32'h0010_0000) $display("FAIL wrap_src20 got %h want 00100000", rd_addr[20]); else n_pass++;
        n_checks++; if (wr_data[20] !== ~32'h0010_0000) $display("FAIL wrap_data20 got %h want %h", wr_data[20], ~32'h0010_0000); else n_pass++;
    endtask

    task automatic test_fault();
        bit ok;
        do_reset();
        dev_fault_on = 3;
        cfgSrcBase = 32'h0004_0000; cfgSrcLen = 16'd10; cfgEnable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock); #1;
            if (fault) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) $display("FAIL fault_set timeout got 0 want 1"); else n_pass++;
        repeat (20) @(negedge clock);
        #1;
        n_checks++; if (fault !== 1'b1) $display("FAIL fault_sticky got %0b want 1", fault); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL fault_idle got %0b want 0", busy); else n_pass++;
        n_checks++; if (wr_cnt !== 2 || rd_cnt !== 3) $display("FAIL fault_norestart got wr=%0d rd=%0d want 2/3", wr_cnt, rd_cnt); else n_pass++;
        n_checks++; if (devOpm !== 5'd0 || memOpm !== 5'd0) $display("FAIL fault_bus_idle got %h/%h want 00/00", devOpm, memOpm); else n_pass++;
`ifdef AUD_PCM_REFILL_IRQ_EN
        n_checks++; if (irqLow !== 1'b1) $display("FAIL fault_irq got %0b want 1", irqLow); else n_pass++;
`endif
        cfgEnable = 1'b0;
        dev_fault_on = 0;
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_hold();
        test_wrap();
        test_fault();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
